// File: rtl/aes_pkg.sv
// Shared AES constants and the add-round-key controller state type.
package aes_pkg;

  localparam int STATE_BYTES = 16;
  localparam int BYTE_W      = 8;
  localparam int STATE_W     = STATE_BYTES * BYTE_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ark_state_e;

endpackage

// File: rtl/add_round_key_ctrl_if.sv
// Request/response bundle of the add-round-key controller.
interface add_round_key_ctrl_if;
  import aes_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] state_in;
  logic [STATE_W-1:0] key_in;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] state_out;
  logic               busy;

  modport master (
    output in_valid, state_in, key_in, out_ready,
    input  in_ready, out_valid, state_out, busy
  );

  modport slave (
    input  in_valid, state_in, key_in, out_ready,
    output in_ready, out_valid, state_out, busy
  );

endinterface

// File: rtl/GF_Adder.sv
// GF(2^8) addition of two bytes.
module GF_Adder (
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  output logic [7:0] out
);

  assign out = in1 ^ in2;

endmodule

// File: rtl/add_round_key_ctrl.sv
// AddRoundKey engine: LANES bytes per cycle over a captured state/key,
// result published only when all 16 bytes are done.
module add_round_key_ctrl
  import aes_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_in,
  input  logic [STATE_W-1:0] key_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out,
  output logic               busy
);

  localparam int N     = STATE_BYTES / LANES;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [STATE_W-1:0] BYTE_MASK =
    {{BYTE_W{1'b1}}, {(STATE_W - BYTE_W){1'b0}}};

  if (LANES != 1 && LANES != 2 && LANES != 4 &&
      LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("add_round_key_ctrl: LANES must be 1, 2, 4, 8 or 16");
  end

  ark_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [STATE_W-1:0] st_q, key_q, res_q, res_d, out_q;
  logic [STATE_W-1:0] st_sh, key_sh;
  logic [BYTE_W-1:0]  a [LANES];
  logic [BYTE_W-1:0]  b [LANES];
  logic [BYTE_W-1:0]  s [LANES];
  int                 sh_r, sh_w;

  // Shift the addressed byte to the top, then take the top byte.
  always_comb begin
    sh_r   = 0;
    st_sh  = '0;
    key_sh = '0;
    for (int l = 0; l < LANES; l++) begin
      sh_r   = BYTE_W * (int'(cnt_q) * LANES + l);
      st_sh  = st_q << sh_r;
      key_sh = key_q << sh_r;
      a[l]   = st_sh[STATE_W-1 -: BYTE_W];
      b[l]   = key_sh[STATE_W-1 -: BYTE_W];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    GF_Adder u_add (
      .in1 (a[l]),
      .in2 (b[l]),
      .out (s[l])
    );
  end

  always_comb begin
    sh_w  = 0;
    res_d = res_q;
    for (int l = 0; l < LANES; l++) begin
      sh_w  = BYTE_W * (int'(cnt_q) * LANES + l);
      res_d = (res_d & ~(BYTE_MASK >> sh_w)) |
              ({s[l], {(STATE_W - BYTE_W){1'b0}}} >> sh_w);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
      key_q   <= '0;
      res_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        st_q  <= state_in;
        key_q <= key_in;
        cnt_q <= '0;
      end
      if (state_q == RUN) begin
        res_q <= res_d;
        if (cnt_q != CNT_LAST) begin
          cnt_q <= cnt_q + 1'b1;
        end else begin
          out_q <= res_d;
        end
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign state_out = out_q;

endmodule

// File: tb/tb_add_round_key_ctrl.sv
// Bench for add_round_key_ctrl: LANES=1 and LANES=4 instances checked
// against a plain state^key reference with a fixed N-cycle latency.
module tb_add_round_key_ctrl;
  import aes_pkg::*;

  typedef struct {
    logic [127:0] s;
    logic [127:0] k;
    logic [127:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic         iv [2];
  logic         ordy [2];
  logic [127:0] sti [2];
  logic [127:0] kyi [2];
  logic         ov [2];
  logic         ir [2];
  logic         bz [2];
  logic [127:0] so [2];

  add_round_key_ctrl_if bus1 ();
  add_round_key_ctrl_if bus4 ();

  assign bus1.in_valid  = iv[0];
  assign bus1.state_in  = sti[0];
  assign bus1.key_in    = kyi[0];
  assign bus1.out_ready = ordy[0];
  assign bus4.in_valid  = iv[1];
  assign bus4.state_in  = sti[1];
  assign bus4.key_in    = kyi[1];
  assign bus4.out_ready = ordy[1];

  assign ov[0] = bus1.out_valid;
  assign ir[0] = bus1.in_ready;
  assign bz[0] = bus1.busy;
  assign so[0] = bus1.state_out;
  assign ov[1] = bus4.out_valid;
  assign ir[1] = bus4.in_ready;
  assign bz[1] = bus4.busy;
  assign so[1] = bus4.state_out;

  add_round_key_ctrl #(.LANES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus1.in_valid),
    .in_ready  (bus1.in_ready),
    .state_in  (bus1.state_in),
    .key_in    (bus1.key_in),
    .out_valid (bus1.out_valid),
    .out_ready (bus1.out_ready),
    .state_out (bus1.state_out),
    .busy      (bus1.busy)
  );

  add_round_key_ctrl #(.LANES(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus4.in_valid),
    .in_ready  (bus4.in_ready),
    .state_in  (bus4.state_in),
    .key_in    (bus4.key_in),
    .out_valid (bus4.out_valid),
    .out_ready (bus4.out_ready),
    .state_out (bus4.state_out),
    .busy      (bus4.busy)
  );

  function automatic int nlat(int d);
    return (d == 0) ? 16 : 4;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic txn(input int d, input logic [127:0] s,
                     input logic [127:0] k, input int hold,
                     input bit noise, output int waited);
    logic [127:0] exp;
    int cyc;
    exp = s ^ k;
    waited = 0;
    while (!ir[d] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_ready", 128'(ir[d]), 128'd1);
    iv[d] = 1'b1;
    sti[d] = s;
    kyi[d] = k;
    ordy[d] = 1'b0;
    @(negedge clk);
    iv[d] = 1'b0;
    cyc = 0;
    while (!ov[d] && cyc < 100) begin
      chk("run_busy", 128'(bz[d]), 128'd1);
      chk("run_no_ready", 128'(ir[d]), 128'd0);
      if (noise) begin
        sti[d] = rnd128();
        kyi[d] = rnd128();
        iv[d] = 1'($urandom_range(0, 1));
        ordy[d] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    iv[d] = 1'b0;
    ordy[d] = 1'b0;
    chk("latency", 128'(cyc), 128'(nlat(d)));
    chk("result", so[d], exp);
    for (int h = 0; h < hold; h++) begin
      iv[d] = 1'b1;
      sti[d] = rnd128();
      @(negedge clk);
      chk("hold_valid", 128'(ov[d]), 128'd1);
      chk("hold_stable", so[d], exp);
      chk("hold_no_ready", 128'(ir[d]), 128'd0);
    end
    iv[d] = 1'b0;
    ordy[d] = 1'b1;
    @(negedge clk);
    ordy[d] = 1'b0;
    chk("release_valid", 128'(ov[d]), 128'd0);
    chk("release_ready", 128'(ir[d]), 128'd1);
    chk("retain", so[d], exp);
  endtask

  task automatic back_to_back(input int d);
    logic [127:0] exp_q[$];
    int acc_t[$];
    int t, got;
    t = 0;
    got = 0;
    ordy[d] = 1'b1;
    while (got < 4 && t < 300) begin
      if (ov[d]) begin
        if (exp_q.size() > 0) chk("b2b_result", so[d], exp_q.pop_front());
        else chk("b2b_spurious", 128'd1, 128'd0);
        got++;
      end
      if (ir[d] && acc_t.size() < 4) begin
        sti[d] = rnd128();
        kyi[d] = rnd128();
        iv[d] = 1'b1;
        exp_q.push_back(sti[d] ^ kyi[d]);
        acc_t.push_back(t);
      end else begin
        iv[d] = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    iv[d] = 1'b0;
    @(negedge clk);
    ordy[d] = 1'b0;
    chk("b2b_count", 128'(got), 128'd4);
    for (int i = 1; i < acc_t.size(); i++)
      chk("b2b_spacing", 128'(acc_t[i] - acc_t[i-1]), 128'(nlat(d) + 2));
  endtask

  vec_t vt [6];
  int w;

  initial begin
    vt[0] = '{128'h00112233445566778899aabbccddeeff,
              128'h000102030405060708090a0b0c0d0e0f,
              128'h00102030405060708090a0b0c0d0e0f0};
    vt[1] = '{{128{1'b1}}, 128'd0, {128{1'b1}}};
    vt[2] = '{{128{1'b1}}, {128{1'b1}}, 128'd0};
    vt[3] = '{128'h0123456789abcdef0123456789abcdef,
              128'hffffffff00000000ffffffff00000000,
              128'hfedcba9889abcdeffedcba9889abcdef};
    vt[4] = '{128'h80000000000000000000000000000001,
              128'h00000000000000000000000000000001,
              128'h80000000000000000000000000000000};
    vt[5] = '{128'h3243f6a8885a308d313198a2e0370734,
              128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h193de3bea0f4e22b9ac68d2ae9f84808};

    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0;
      ordy[d] = 1'b0;
      sti[d] = '0;
      kyi[d] = '0;
    end
    rst_n = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 128'(ov[d]), 128'd0);
      chk("rst_busy", 128'(bz[d]), 128'd0);
      chk("rst_out", so[d], 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk("rst_ready", 128'(ir[d]), 128'd1);

    for (int i = 0; i < 6; i++) begin
      chk("table_ref", vt[i].s ^ vt[i].k, vt[i].exp);
      txn(0, vt[i].s, vt[i].k, 0, 1'b0, w);
      txn(1, vt[i].s, vt[i].k, 0, 1'b1, w);
    end

    // Stalled consumer, then an immediate follow-on request.
    txn(0, vt[0].s, vt[0].k, 5, 1'b0, w);
    txn(0, vt[5].s, vt[5].k, 0, 1'b0, w);
    chk("next_accept_wait", 128'(w), 128'd0);

    // Abort mid-run with an async reset.
    iv[0] = 1'b1;
    sti[0] = vt[3].s;
    kyi[0] = vt[3].k;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_abort_busy", 128'(bz[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 128'(ov[0]), 128'd0);
    chk("abort_out", so[0], 128'd0);
    chk("abort_busy", 128'(bz[0]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 128'(ir[0]), 128'd1);
    chk("abort_no_valid", 128'(ov[0]), 128'd0);
    txn(0, vt[5].s, vt[5].k, 1, 1'b0, w);

    for (int i = 0; i < 10; i++) begin
      txn(0, rnd128(), rnd128(), $urandom_range(0, 3), 1'b1, w);
      txn(1, rnd128(), rnd128(), $urandom_range(0, 3), 1'b1, w);
    end

    back_to_back(1);
    back_to_back(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
